// File: rtl/decode_stage_piped.sv
// Registered RV32I + accelerator decode stage with two-level forwarding,
// load-use / accelerator-busy bubbles, flush and the ID/EX register.
module decode_stage_piped #(
    parameter int         XLEN      = 32,
    parameter logic [6:0] ACCEL_OP0 = 7'b1111110,
    parameter logic [6:0] ACCEL_OP1 = 7'b1111111,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr_in,
    input  logic [XLEN-1:0]  pc_in,
    output logic [4:0]       rf_rs1_addr,
    output logic [4:0]       rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic             fwd_mem_valid,
    input  logic [4:0]       fwd_mem_rd,
    input  logic [XLEN-1:0]  fwd_mem_data,
    input  logic             fwd_wb_valid,
    input  logic [4:0]       fwd_wb_rd,
    input  logic [XLEN-1:0]  fwd_wb_data,
    input  logic             accel_busy,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             out_valid,
    output logic [31:0]      instr_out,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  imm_out,
    output logic [XLEN-1:0]  rs1_data_out,
    output logic [XLEN-1:0]  rs2_data_out,
    output logic [4:0]       rd_out,
    output logic [4:0]       rs1_out,
    output logic [4:0]       rs2_out,
    output logic             rd_valid_out,
    output logic             is_accel_out,
    output logic             is_load_out,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic            is_r, is_i, is_s, is_b, is_u, is_j;
    logic            is_accel, is_load;
    logic            uses_rs1, uses_rs2, rd_valid;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1, op2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [4:0]      rs2_idx;
    logic            load_use, accel_stall, hazard, hold;

    assign opcode = instr_in[6:0];
    assign rd     = instr_in[11:7];
    assign rs1    = instr_in[19:15];
    assign rs2    = instr_in[24:20];

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    assign is_r     = opcode == 7'b0110011;
    assign is_load  = opcode == 7'b0000011;
    assign is_i     = opcode == 7'b0010011 || is_load
                   || opcode == 7'b1100111;
    assign is_s     = opcode == 7'b0100011;
    assign is_b     = opcode == 7'b1100011;
    assign is_u     = opcode == 7'b0110111 || opcode == 7'b0010111;
    assign is_j     = opcode == 7'b1101111;
    assign is_accel = opcode == ACCEL_OP0 || opcode == ACCEL_OP1;

    assign uses_rs1 = !(is_u || is_j || is_accel);
    assign uses_rs2 = is_r || is_s || is_b;
    assign rd_valid = in_valid && !(is_s || is_b) && rd != 5'd0;

    always_comb begin
        imm32 = 32'd0;
        unique case (1'b1)
            is_i: imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
            is_s: imm32 = {{20{instr_in[31]}}, instr_in[31:25],
                           instr_in[11:7]};
            is_b: imm32 = {{19{instr_in[31]}}, instr_in[31],
                           instr_in[7], instr_in[30:25],
                           instr_in[11:8], 1'b0};
            is_u: imm32 = {instr_in[31:12], 12'd0};
            is_j: imm32 = {{11{instr_in[31]}}, instr_in[31],
                           instr_in[19:12], instr_in[20],
                           instr_in[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    // Nearest producer wins: EX/MEM result is younger than MEM/WB.
    always_comb begin
        op1 = rf_rs1_data;
        if (rs1 == 5'd0)
            op1 = '0;
        else if (fwd_mem_valid && fwd_mem_rd == rs1)
            op1 = fwd_mem_data;
        else if (fwd_wb_valid && fwd_wb_rd == rs1)
            op1 = fwd_wb_data;
    end

    always_comb begin
        op2 = rf_rs2_data;
        if (rs2 == 5'd0)
            op2 = '0;
        else if (fwd_mem_valid && fwd_mem_rd == rs2)
            op2 = fwd_mem_data;
        else if (fwd_wb_valid && fwd_wb_rd == rs2)
            op2 = fwd_wb_data;
    end

    // Accelerator commands carry the rs1 index itself as the operand.
    assign rs1_val = is_accel ? XLEN'(rs1) : op1;
    assign rs2_val = is_accel ? '0 : op2;
    assign rs2_idx = is_accel ? 5'd0 : rs2;

    assign load_use = out_valid && is_load_out && rd_out != 5'd0
                   && ((uses_rs1 && rs1 == rd_out)
                    || (uses_rs2 && rs2 == rd_out));
    assign accel_stall = is_accel && accel_busy;
    assign hazard      = in_valid && (load_use || accel_stall);
    assign hold        = out_valid && !ex_ready;
    assign in_ready    = !reset && (flush || (!hold && !hazard));

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            instr_out    <= '0;
            pc_out       <= '0;
            imm_out      <= '0;
            rs1_data_out <= '0;
            rs2_data_out <= '0;
            rd_out       <= '0;
            rs1_out      <= '0;
            rs2_out      <= '0;
            rd_valid_out <= 1'b0;
            is_accel_out <= 1'b0;
            is_load_out  <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            if (hazard && !hold && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush) begin
                out_valid <= 1'b0;
            end else if (hold) begin
                out_valid <= out_valid;
            end else if (hazard) begin
                out_valid <= 1'b0;
            end else if (in_valid) begin
                out_valid    <= 1'b1;
                instr_out    <= instr_in;
                pc_out       <= pc_in;
                imm_out      <= (is_r || is_accel) ? '0 : imm;
                rs1_data_out <= rs1_val;
                rs2_data_out <= rs2_val;
                rd_out       <= rd;
                rs1_out      <= rs1;
                rs2_out      <= rs2_idx;
                rd_valid_out <= rd_valid;
                is_accel_out <= is_accel;
                is_load_out  <= is_load;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_piped.sv
// Scoreboard bench for decode_stage_piped: expected ID/EX payloads are
// queued at issue and matched by a monitor whenever out_valid is high.
module tb_decode_stage_piped;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready;
    logic [31:0] instr_in, pc_in;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        fwd_mem_valid, fwd_wb_valid;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        accel_busy, flush, ex_ready;
    logic        out_valid;
    logic [31:0] instr_out, pc_out, imm_out, rs1_data_out, rs2_data_out;
    logic [4:0]  rd_out, rs1_out, rs2_out;
    logic        rd_valid_out, is_accel_out, is_load_out;
    logic [15:0] stall_cnt;

    logic        d2_in_ready, d2_out_valid;
    logic [4:0]  d2_rs1a, d2_rs2a, d2_rd, d2_rs1, d2_rs2;
    logic [31:0] d2_instr, d2_pc, d2_imm, d2_r1d, d2_r2d;
    logic        d2_rdv, d2_acc, d2_ld;
    logic [3:0]  d2_stall_cnt;

    typedef struct packed {
        logic [31:0] instr, pc, imm, rs1d, rs2d;
        logic [4:0]  rd, rs1, rs2;
        logic        rdv, acc, ld;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_stage_piped dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd),
        .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd),
        .fwd_wb_data(fwd_wb_data),
        .accel_busy(accel_busy), .flush(flush), .ex_ready(ex_ready),
        .out_valid(out_valid), .instr_out(instr_out), .pc_out(pc_out),
        .imm_out(imm_out), .rs1_data_out(rs1_data_out),
        .rs2_data_out(rs2_data_out), .rd_out(rd_out), .rs1_out(rs1_out),
        .rs2_out(rs2_out), .rd_valid_out(rd_valid_out),
        .is_accel_out(is_accel_out), .is_load_out(is_load_out),
        .stall_cnt(stall_cnt)
    );

    decode_stage_piped #(.CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_ready(d2_in_ready),
        .instr_in(instr_in), .pc_in(pc_in),
        .rf_rs1_addr(d2_rs1a), .rf_rs2_addr(d2_rs2a),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd),
        .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd),
        .fwd_wb_data(fwd_wb_data),
        .accel_busy(accel_busy), .flush(flush), .ex_ready(ex_ready),
        .out_valid(d2_out_valid), .instr_out(d2_instr), .pc_out(d2_pc),
        .imm_out(d2_imm), .rs1_data_out(d2_r1d), .rs2_data_out(d2_r2d),
        .rd_out(d2_rd), .rs1_out(d2_rs1), .rs2_out(d2_rs2),
        .rd_valid_out(d2_rdv), .is_accel_out(d2_acc),
        .is_load_out(d2_ld), .stall_cnt(d2_stall_cnt)
    );

    function automatic exp_t mk(
        input logic [31:0] ins, p, im, r1d, r2d,
        input logic [4:0]  rd, r1, r2,
        input logic        rdv, acc, ld
    );
        exp_t e;
        e.instr = ins; e.pc = p; e.imm = im;
        e.rs1d = r1d; e.rs2d = r2d;
        e.rd = rd; e.rs1 = r1; e.rs2 = r2;
        e.rdv = rdv; e.acc = acc; e.ld = ld;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] p);
        in_valid = 1'b1;
        instr_in = ins;
        pc_in    = p;
    endtask

    // Compares every presented payload; retires it when EX takes it.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            exp_t act;
            act = {instr_out, pc_out, imm_out, rs1_data_out, rs2_data_out,
                   rd_out, rs1_out, rs2_out,
                   rd_valid_out, is_accel_out, is_load_out};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %h expected none", act);
            end else begin
                if (act !== sb[0]) begin
                    errors++;
                    $display("FAIL payload: got %h expected %h", act, sb[0]);
                end
                if (ex_ready)
                    void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; instr_in = '0; pc_in = '0;
        rf_rs1_data = 32'h33; rf_rs2_data = 32'h44;
        fwd_mem_valid = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
        fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
        accel_busy = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        cyc(); cyc();
        #2;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_instr", 64'(instr_out), 0);
        chk("rst_imm", 64'(imm_out), 0);
        chk("rst_stall", 64'(stall_cnt), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
        cyc();

        // ADDI x1,x0,5
        reset = 1'b0;
        issue(32'h00500093, 32'h100);
        #2 chk("addi_ready", 64'(in_ready), 1);
        sb.push_back(mk(32'h00500093, 32'h100, 5, 0, 32'h44,
                        1, 0, 5, 1, 0, 0));
        cyc();

        // LW x2,0(x1)
        issue(32'h0000A103, 32'h104);
        #2 chk("lw_ready", 64'(in_ready), 1);
        sb.push_back(mk(32'h0000A103, 32'h104, 0, 32'h33, 0,
                        2, 1, 0, 1, 0, 1));
        cyc();

        // ADD x3,x2,x2 hits load-use
        issue(32'h002101B3, 32'h108);
        #2 chk("loaduse_ready", 64'(in_ready), 0);
        cyc();

        fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd2; fwd_mem_data = 32'hAB;
        #2;
        chk("bubble_valid", 64'(out_valid), 0);
        chk("loaduse_stall", 64'(stall_cnt), 1);
        chk("add_ready", 64'(in_ready), 1);
        sb.push_back(mk(32'h002101B3, 32'h108, 0, 32'hAB, 32'hAB,
                        3, 2, 2, 1, 0, 0));
        cyc();

        // ADDI x6,x5,0: mem and wb both target x5
        issue(32'h00028313, 32'h10C);
        fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'h11;
        fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'h22;
        #2 chk("fwd_ready", 64'(in_ready), 1);
        sb.push_back(mk(32'h00028313, 32'h10C, 0, 32'h11, 0,
                        6, 5, 0, 1, 0, 0));
        cyc();

        issue(32'h00028313, 32'h110);
        fwd_mem_rd = 5'd7;
        sb.push_back(mk(32'h00028313, 32'h110, 0, 32'h22, 0,
                        6, 5, 0, 1, 0, 0));
        cyc();

        // ADDI x6,x0,0 with both bypasses claiming x0
        issue(32'h00000313, 32'h114);
        fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
        sb.push_back(mk(32'h00000313, 32'h114, 0, 0, 0,
                        6, 0, 0, 1, 0, 0));
        cyc();

        in_valid = 1'b0; fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
        cyc();
        #2 chk("idle_valid", 64'(out_valid), 0);
        reset = 1'b1;
        cyc();

        // Accelerator command stalled by accel_busy for 3 cycles
        reset = 1'b0;
        issue(32'h0002A0FF, 32'h200);
        accel_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("accel_busy_ready", 64'(in_ready), 0);
            chk("accel_busy_valid", 64'(out_valid), 0);
            cyc();
        end
        accel_busy = 1'b0;
        #2;
        chk("accel_ready", 64'(in_ready), 1);
        chk("accel_stall", 64'(stall_cnt), 3);
        sb.push_back(mk(32'h0002A0FF, 32'h200, 0, 5, 0,
                        1, 5, 0, 1, 1, 0));
        cyc();

        // Back-pressure: accel payload frozen for 4 cycles
        ex_ready = 1'b0;
        issue(32'h00900393, 32'h204);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("hold_ready", 64'(in_ready), 0);
            chk("hold_valid", 64'(out_valid), 1);
            chk("hold_instr", 64'(instr_out), 64'h0002A0FF);
            cyc();
        end
        ex_ready = 1'b1;
        #2 chk("release_ready", 64'(in_ready), 1);
        sb.push_back(mk(32'h00900393, 32'h204, 9, 0, 32'h44,
                        7, 0, 9, 1, 0, 0));
        cyc();

        // Flush while both held and hazarded
        ex_ready = 1'b0; flush = 1'b1; accel_busy = 1'b1;
        issue(32'h0002A0FF, 32'h208);
        #2 chk("flush_ready", 64'(in_ready), 1);
        cyc();
        flush = 1'b0; in_valid = 1'b0; accel_busy = 1'b0; ex_ready = 1'b1;
        if (sb.size() > 0)
            void'(sb.pop_front());
        #2;
        chk("flush_valid", 64'(out_valid), 0);
        chk("flush_no_stall", 64'(stall_cnt), 3);
        cyc();

        // Counter saturation on the 4-bit instance
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        issue(32'h0002A0FF, 32'h300);
        accel_busy = 1'b1;
        for (int i = 0; i < 14; i++) cyc();
        #2 chk("sat_pre", 64'(d2_stall_cnt), 14);
        for (int i = 0; i < 6; i++) cyc();
        #2;
        chk("sat_cnt4", 64'(d2_stall_cnt), 15);
        chk("sat_cnt16", 64'(stall_cnt), 20);
        chk("sat_valid", 64'(out_valid), 0);
        cyc();

        // Reset in the middle of a stall
        reset = 1'b1;
        #2 chk("rst_mid_ready", 64'(in_ready), 0);
        cyc();
        reset = 1'b0; in_valid = 1'b0; accel_busy = 1'b0;
        #2;
        chk("rst_mid_stall", 64'(stall_cnt), 0);
        chk("rst_mid_cnt4", 64'(d2_stall_cnt), 0);
        chk("rst_mid_valid", 64'(out_valid), 0);
        cyc();
        #2 chk("no_replay", 64'(out_valid), 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
        chk("sb_drained", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage_piped.md
# decode_stage_piped

Registered, hazard-aware instruction decode stage: successor to the combinational decoder, sitting between the IF/ID register and the execute stage / accelerator dispatch of the RISC-V SoC. The block decodes RV32I plus the custom accelerator opcodes and resolves operands through a two-level forwarding network. It detects load-use and accelerator-busy hazards, inserts bubbles, honours branch flush, and owns the ID/EX pipeline register behind a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, datapath / PC width
- ACCEL_OP0, 7'b1111110, first custom accelerator opcode
- ACCEL_OP1, 7'b1111111, second custom accelerator opcode
- CNT_W, 16, width of stall performance counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  decode accepts instruction this cycle (combinational)
- instr_in  in  32  instruction word
- pc_in  in  XLEN  instruction PC
- rf_rs1_addr / rf_rs2_addr  out  5  regfile read addresses = instr_in[19:15] / [24:20] (combinational)
- rf_rs1_data / rf_rs2_data  in  XLEN  regfile read data, same cycle
- fwd_mem_valid, fwd_mem_rd, fwd_mem_data  in  1/5/XLEN  EX/MEM write-back bypass
- fwd_wb_valid, fwd_wb_rd, fwd_wb_data  in  1/5/XLEN  MEM/WB write-back bypass
- accel_busy  in  1  accelerator cannot take a new command
- flush  in  1  branch/jump redirect; kill decode contents
- ex_ready  in  1  execute stage consumes ID/EX this cycle
- out_valid  out  1  ID/EX holds valid instruction
- instr_out, pc_out, imm_out, rs1_data_out, rs2_data_out  out  32/XLEN/XLEN/XLEN/XLEN  registered decode results
- rd_out, rs1_out, rs2_out  out  5  registered register indices
- rd_valid_out, is_accel_out, is_load_out  out  1  registered flags
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Decode classes: R 0110011; I 0010011/0000011/1100111; S 0100011; B 1100011; U 0110111/0010111; J 1101111; accel = ACCEL_OP0/ACCEL_OP1; load = 0000011.
- imm: standard RV32 sign-extended I/S/B/U/J formats; 0 for R, accel and unknown opcodes.
- uses_rs1 = not U/J/accel; uses_rs2 = R/S/B only.
- rd_valid = in_valid && opcode not S/B && rd != 0.
- Operand select per source, priority: x0 -> 0; fwd_mem match (valid, rd equal, rd!=0); fwd_wb match; rf data.
- Accel: rs1_data_out = zero-extended rs1 index, rs2_data_out = 0, rs2_out = 0, rd_out = instr[11:7].
- load_use = out_valid && is_load_out && rd_out!=0 && ((uses_rs1 && rs1==rd_out) || (uses_rs2 && rs2==rd_out)).
- accel_stall = is_accel && accel_busy.
- hazard = in_valid && (load_use || accel_stall).
- hold = out_valid && !ex_ready.
- in_ready = !hold && !hazard && !reset. During flush, in_ready = 1: the instruction is accepted and discarded.
- ID/EX update priority: reset -> all outputs 0; flush -> out_valid<=0; hold -> keep all; hazard -> out_valid<=0 (bubble); in_valid -> load decode, out_valid<=1; else out_valid<=0.
- stall_cnt increments when hazard && !hold && !flush; saturates at all-ones; cleared only by reset.

## Timing
- Latency 1 cycle: accepted at edge N, visible on outputs after edge N.
- Reset value: every registered output and stall_cnt is 0.
- Load-use: exactly one bubble. The load advances, out_valid is 0 for one cycle, and the dependent instruction is accepted on the following edge with the load result on fwd_mem.
- Accel stall: lasts while accel_busy is 1; the instruction is accepted on the first cycle accel_busy is 0.
- Flush takes effect in the same cycle as hold and hazard, and overrides both.
- Reset mid-stall: drops everything; no instruction is replayed.
- Held contents must be stable: payload does not change while out_valid && !ex_ready.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with ex_ready=1: after one edge, out_valid=1, imm_out=5, rd_out=1, rd_valid_out=1, rs1_data_out=0.
- LW x2,0(x1) then ADD x3,x2,x2: one bubble (out_valid=0); stall_cnt=1; ADD is issued next with fwd_mem_rd=2 data 0xAB, giving rs1_data_out=rs2_data_out=0xAB.
- Forwarding priority: mem and wb both target x5 (0x11 / 0x22), rf=0x33 -> rs1_data_out=0x11. With x0 targeted by both, the result is 0.
- Accel op 0x0002A0FF with accel_busy=1 for 3 cycles: in_ready=0 for 3 cycles, stall_cnt=3. Issue then gives rs1_data_out=5, rs2_out=0, is_accel_out=1.
- ex_ready=0 for 4 cycles with out_valid=1: outputs are frozen and in_ready=0. Asserting flush then gives out_valid=0 on the next edge.
- stall_cnt with CNT_W=4 over 20 stall cycles: value saturates at 15.
